// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing block.
// Defaults describe 640x480@60 Hz.
package vga_timing_pkg;

  localparam int POS_W = 10;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  typedef struct packed {
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
  } vga_pos_t;

  function automatic int h_total(int disp, int front, int sync, int back);
    return disp + front + sync + back;
  endfunction

  function automatic int v_total(int disp, int front, int sync, int back);
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-N counter with enable. Exposes the next-state value so the parent can
// register flags that line up with the count it will present.
module vga_wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int N = 800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [POS_W-1:0] count,
  output logic [POS_W-1:0] count_next,
  output logic             wrap
);

  localparam logic [POS_W-1:0] LAST = POS_W'(N - 1);

  logic [POS_W-1:0] count_q, count_d;

  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (en) count_d = wrap ? '0 : count_q + POS_W'(1);
  end

  // Reset to the last position so the first enabled step lands on 0.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= LAST;
    else        count_q <= count_d;
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: position counters plus sync, display-enable and
// line/frame strobes, all registered from the next-state position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = H_DISPLAY_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_DISPLAY  = V_DISPLAY_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam logic [POS_W-1:0] H_DISP_END = POS_W'(H_DISPLAY);
  localparam logic [POS_W-1:0] V_DISP_END = POS_W'(V_DISPLAY);
  localparam logic [POS_W-1:0] HS_START   = POS_W'(H_DISPLAY + H_FRONT);
  localparam logic [POS_W-1:0] HS_END     = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [POS_W-1:0] VS_START   = POS_W'(V_DISPLAY + V_FRONT);
  localparam logic [POS_W-1:0] VS_END     = POS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic             HS_ACT     = (H_SYNC_POL != 0);
  localparam logic             VS_ACT     = (V_SYNC_POL != 0);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
  endgenerate

  vga_pos_t   pos_q, pos_d;
  logic       h_wrap, v_wrap;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_q, disp_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic [7:0] fcnt_q, fcnt_d;

  vga_wrap_counter #(.N(H_TOTAL)) u_hcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (pix_en),
    .count      (pos_q.hpos),
    .count_next (pos_d.hpos),
    .wrap       (h_wrap)
  );

  vga_wrap_counter #(.N(V_TOTAL)) u_vcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (pix_en & h_wrap),
    .count      (pos_q.vpos),
    .count_next (pos_d.vpos),
    .wrap       (v_wrap)
  );

  // Flags follow the next position; with pix_en low that equals the current
  // one, so levels hold while strobes are gated off.
  always_comb begin
    hsync_d = (pos_d.hpos >= HS_START && pos_d.hpos <= HS_END) ? HS_ACT : ~HS_ACT;
    vsync_d = (pos_d.vpos >= VS_START && pos_d.vpos <= VS_END) ? VS_ACT : ~VS_ACT;
    disp_d  = (pos_d.hpos < H_DISP_END) && (pos_d.vpos < V_DISP_END);
    ls_d    = pix_en && (pos_d.hpos == '0);
    fs_d    = ls_d && (pos_d.vpos == '0);
    fcnt_d  = fcnt_q;
    if (fs_d) fcnt_d = fcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q <= ~HS_ACT;
      vsync_q <= ~VS_ACT;
      disp_q  <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      disp_q  <= disp_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign hpos        = pos_q.hpos;
  assign vpos        = pos_q.vpos;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = disp_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster:
// 15 columns (8/2/3/2) x 11 lines (6/1/2/2), 165 clocks per frame.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [9:0] hpos, vpos;
  logic       hsync, vsync, display_on, line_start, frame_start;
  logic [7:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_SYNC_POL(0), .V_SYNC_POL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample on the falling edge.
  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n_hs, n_vs, n_de, n_ls, n_fs, fs_idx;
    int hs_min, hs_max, vs_min, vs_max;

    rst_n = 1'b0;
    pix_en = 1'b0;
    @(negedge clk);
    step(1'b0);
    step(1'b0);
    chk("rst_hpos", hpos, 14);
    chk("rst_vpos", vpos, 10);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", display_on, 0);
    chk("rst_ls", line_start, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_fcnt", frame_cnt, 0);

    // Full frame at pix_en=1, first step lands on (0,0).
    rst_n = 1'b1;
    n_hs = 0; n_vs = 0; n_de = 0; n_ls = 0; n_fs = 0;
    hs_min = 1023; hs_max = 0; vs_min = 1023; vs_max = 0;
    for (int i = 0; i < 165; i++) begin
      step(1'b1);
      if (i == 0) begin
        chk("first_hpos", hpos, 0);
        chk("first_vpos", vpos, 0);
        chk("first_de", display_on, 1);
        chk("first_ls", line_start, 1);
        chk("first_fs", frame_start, 1);
        chk("first_fcnt", frame_cnt, 1);
      end
      if (i == 1) chk("second_ls", line_start, 0);
      if (i == 15) begin
        chk("line1_hpos", hpos, 0);
        chk("line1_vpos", vpos, 1);
        chk("line1_ls", line_start, 1);
      end
      if (i == 82) begin
        chk("corner_hpos", hpos, 7);
        chk("de_7_5", display_on, 1);
      end
      if (i == 83) chk("de_8_5", display_on, 0);
      if (i == 90) chk("de_0_6", display_on, 0);
      if (!hsync) begin
        n_hs++;
        if (hpos < hs_min) hs_min = hpos;
        if (hpos > hs_max) hs_max = hpos;
      end
      if (!vsync) begin
        n_vs++;
        if (vpos < vs_min) vs_min = vpos;
        if (vpos > vs_max) vs_max = vpos;
      end
      if (display_on) n_de++;
      if (line_start) n_ls++;
      if (frame_start) n_fs++;
    end
    chk("hs_cycles", n_hs, 33);
    chk("hs_first", hs_min, 10);
    chk("hs_last", hs_max, 12);
    chk("vs_cycles", n_vs, 30);
    chk("vs_first", vs_min, 7);
    chk("vs_last", vs_max, 8);
    chk("de_cycles", n_de, 48);
    chk("ls_count", n_ls, 11);
    chk("fs_count", n_fs, 1);
    chk("end_hpos", hpos, 14);
    chk("end_vpos", vpos, 10);

    // Simultaneous wrap from the last position.
    step(1'b1);
    chk("wrap_hpos", hpos, 0);
    chk("wrap_vpos", vpos, 0);
    chk("wrap_ls", line_start, 1);
    chk("wrap_fs", frame_start, 1);
    chk("wrap_fcnt", frame_cnt, 2);

    // pix_en one clock in four.
    n_ls = 0; n_fs = 0; fs_idx = -1;
    for (int i = 0; i < 660; i++) begin
      step((i % 4) == 3);
      if (i == 2) begin
        chk("div_hold_hpos", hpos, 0);
        chk("div_hold_ls", line_start, 0);
        chk("div_hold_fs", frame_start, 0);
      end
      if (i == 3) chk("div_step_hpos", hpos, 1);
      if (line_start) n_ls++;
      if (frame_start) begin
        n_fs++;
        fs_idx = i;
      end
    end
    chk("div_ls_count", n_ls, 11);
    chk("div_fs_count", n_fs, 1);
    chk("div_period", fs_idx + 1, 660);
    chk("div_fcnt", frame_cnt, 3);

    // Frame counter rollover.
    for (int f = 1; f <= 253; f++) begin
      for (int i = 0; i < 165; i++) step(1'b1);
      if (f >= 252) begin
        chk("roll_fs", frame_start, 1);
        chk("roll_fcnt", frame_cnt, (f == 252) ? 255 : 0);
      end
    end

    // Mid-frame reset inside both sync windows at (11,7).
    for (int i = 0; i < 116; i++) step(1'b1);
    chk("mid_hpos", hpos, 11);
    chk("mid_vpos", vpos, 7);
    chk("mid_hsync", hsync, 0);
    chk("mid_vsync", vsync, 0);
    rst_n = 1'b0;
    step(1'b1);
    chk("mrst_hpos", hpos, 14);
    chk("mrst_vpos", vpos, 10);
    chk("mrst_hsync", hsync, 1);
    chk("mrst_vsync", vsync, 1);
    chk("mrst_de", display_on, 0);
    chk("mrst_fcnt", frame_cnt, 0);
    rst_n = 1'b1;
    step(1'b1);
    chk("rel_hpos", hpos, 0);
    chk("rel_vpos", vpos, 0);
    chk("rel_fs", frame_start, 1);
    chk("rel_fcnt", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA pipeline. It produces registered horizontal and vertical counters, sync pulses, a display-enable flag and frame/line strobes. It sits directly upstream of the pixel renderer, which consumes `hpos`/`vpos`/`display_on` combinationally and packs `hsync`/`vsync` into `uo_out`. A per-cycle pixel enable lets the same block run from a 25.175 MHz clock (`pix_en` tied high) or from a faster clock with a divided strobe.

## Interface
Parameters:
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_DISPLAY`, 480, visible lines
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width
- `V_BACK`, 33, vertical back porch
- `H_SYNC_POL`, 0, active level of `hsync` (0 = active-low)
- `V_SYNC_POL`, 0, active level of `vsync`

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `pix_en`  in  1  pixel-advance enable; the counters step only when it is high
- `hpos`  out  10  current column, 0..H_TOTAL-1
- `vpos`  out  10  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, polarity per `H_SYNC_POL`
- `vsync`  out  1  vertical sync, polarity per `V_SYNC_POL`
- `display_on`  out  1  high when `hpos<H_DISPLAY && vpos<V_DISPLAY`
- `line_start`  out  1  one-clk pulse when `hpos` becomes 0
- `frame_start`  out  1  one-clk pulse when `hpos` and `vpos` both become 0
- `frame_cnt`  out  8  frame counter

## Operation
- Derived totals:
  - `H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK` (default 800).
  - `V_TOTAL` is defined the same way (default 525).
  - Both totals must be ≤1024; the block elaborates with an error otherwise.
- Horizontal counter:
  - On a `pix_en` cycle, `hpos` increments.
  - At `H_TOTAL-1` it wraps to 0 and `vpos` steps.
- Vertical counter: `vpos` increments on each `hpos` wrap and wraps from `V_TOTAL-1` to 0.
- Sync windows:
  - `hsync` is active while `hpos ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]` (default 656..751).
  - `vsync` is active while `vpos ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]` (default 490..491).
  - Outside these windows each sync sits at its inactive level.
- `vsync` is a function of `vpos` only; it changes on the same cycle `vpos` changes, i.e. at an `hpos` wrap.
- Strobes:
  - `line_start` and `frame_start` assert only in the clk cycle where the new position is presented.
  - They are low in every other cycle, including `pix_en`-low cycles that hold that same position.
- `frame_cnt` increments by 1 on every `frame_start` and wraps from 255 to 0.
- When `pix_en` is low, `hpos`, `vpos`, the syncs, `display_on` and `frame_cnt` hold.

## Timing
- All outputs are registered and mutually consistent: `hsync`, `vsync`, `display_on` and the strobes describe the `hpos`/`vpos` presented in the same cycle. They are computed from the next-state counter values; there is no skew between position and flags.
- Reset values, chosen so the first enabled cycle lands on (0,0):
  - `hpos=H_TOTAL-1` (799), `vpos=V_TOTAL-1` (524)
  - `hsync` and `vsync` inactive
  - `display_on=0`, `line_start=0`, `frame_start=0`, `frame_cnt=0`
- Latency: one `pix_en` cycle after reset release gives `hpos=0`, `vpos=0`, `display_on=1`, `line_start=1`, `frame_start=1` and `frame_cnt=1`.
- Simultaneous wrap: at `hpos` 799→0 with `vpos` 524→0, both counters update in the same cycle; `line_start` and `frame_start` both assert.
- Reset asserted mid-frame: on the next clk edge all outputs return to their reset values regardless of `pix_en`.
- Sync pulse widths are exactly `H_SYNC` pix_en cycles and `V_SYNC` lines.

## Structure
- Package `vga_timing_pkg` holds:
  - the default 640x480@60 porch/sync constants;
  - derived `H_TOTAL`/`V_TOTAL` functions;
  - a `vga_pos_t` typedef (10-bit `hpos`/`vpos` pair).
- Sub-module `vga_wrap_counter` is a parameterized modulo-N counter with enable. It has outputs `count` and `wrap` (the wrap-this-cycle flag) and is instantiated once for horizontal and once for vertical. Vertical enable is `pix_en & h_wrap`.

## Test plan
- **Reset release, `pix_en`=1:**
  - The first cycle shows `hpos=0`, `vpos=0`, `display_on=1`, `line_start=1`, `frame_start=1`, `frame_cnt=1`.
  - After 800 cycles `line_start` pulses with `vpos=1`.
- **Full frame, `pix_en`=1:**
  - Exactly 96 cycles of `hsync` low per line, starting at `hpos=656`.
  - `vsync` low for lines 490–491 (1600 cycles).
  - `frame_start` period is 420000 cycles.
- **`pix_en` toggling 1-of-4:**
  - Counters advance once per 4 clks.
  - Strobes are 1 clk wide, not 4.
  - Frame period is 1,680,000 clks.
- **Display window:** `display_on` is high for (639,479) and low for (640,479) and (0,480); 307200 active pixels per frame.
- **Wrap and counter rollover:**
  - Run 256 frames; `frame_cnt` wraps 255→0 on the 256th `frame_start`.
  - At the 799/524→0/0 transition, both strobes are high in one cycle.
- **Mid-frame reset:**
  - Assert `rst_n=0` at `hpos=700`, `vpos=300`.
  - Next cycle: `hpos=799`, `vpos=524`, syncs inactive, `frame_cnt=0`.
  - On release, the frame restarts at (0,0) with `frame_start=1`.
